// File: rtl/wr_port_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ valid/ready requesters.
// Grants one requester per burst of up to MAXBURST words and honours wfull.
module wr_port_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAXBURST = 4
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    gnt,
  input  logic               wfull,
  output logic               winc,
  output logic [DW-1:0]      wdata,
  output logic               busy
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(MAXBURST) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MAXBURST - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(NREQ - 1);

  localparam logic StIdle  = 1'b0;
  localparam logic StBurst = 1'b1;

  logic            state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [PtrW-1:0] gidx;
  logic [PtrW-1:0] sel;
  logic            g_valid;

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) gidx = PtrW'(i);
    end
  end

  // First valid requester scanning from ptr upward with wrap.
  always_comb begin
    logic found;
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        sel   = PtrW'(idx);
        found = 1'b1;
      end
    end
  end

  // gnt_q is all-zero in idle, so these outputs fall to zero there without extra gating.
  always_comb begin
    g_valid   = |(gnt_q & req_valid);
    req_ready = wfull ? '0 : gnt_q;
    winc      = g_valid & ~wfull;
    wdata     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) wdata = wdata | req_data[i*DW +: DW];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (|req_valid) begin
          state_d    = StBurst;
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          cnt_d      = '0;
        end
      end
      StBurst: begin
        // Release wins over a stall; a stall alone never ends the burst.
        if (!g_valid || (winc && cnt_q == CntLast)) begin
          state_d = StIdle;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = (gidx == PtrLast) ? '0 : gidx + PtrW'(1);
        end else if (winc) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q == StBurst);

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Directed bench for wr_port_arbiter: NREQ=4, DW=8, MAXBURST=4.
// Each requester drives data {index, word number} and advances on an accepted handshake.
module tb_wr_port_arbiter;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned DW       = 8;
  localparam int unsigned MAXBURST = 4;

  logic               wclk;
  logic               wrst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    gnt;
  logic               wfull;
  logic               winc;
  logic [DW-1:0]      wdata;
  logic               busy;

  int checks;
  int errors;
  int wcnt [NREQ];

  wr_port_arbiter #(
    .NREQ     (NREQ),
    .DW       (DW),
    .MAXBURST (MAXBURST)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .gnt       (gnt),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .busy      (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*DW +: DW] = 8'((i << 4) | (wcnt[i] & 15));
    end
  endtask

  // Advance one clock; requesters whose word was accepted move on to the next word.
  task automatic step();
    logic [NREQ-1:0] acc;
    #1;
    acc = req_valid & req_ready;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) wcnt[i]++;
    end
    drive_data();
  endtask

  task automatic do_reset();
    wrst_n    = 1'b0;
    req_valid = '0;
    wfull     = 1'b0;
    for (int i = 0; i < NREQ; i++) wcnt[i] = 0;
    drive_data();
    @(posedge wclk);
    #1;
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    wrst_n    = 1'b0;
    req_valid = 4'b1111;
    wfull     = 1'b0;
    drive_data();
    #2;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL reset_winc got %b exp 0", winc); end
    checks++; if (wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h exp 00", wdata); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", dut.ptr_q); end
    checks++; if (dut.cnt_q !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", dut.cnt_q); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_idle_gnt got %b exp 0000", gnt); end
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL single_idle_winc got %b exp 0", winc); end
    step();
    for (int w = 0; w < 4; w++) begin
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt w%0d got %b exp 0001", w, gnt); end
      checks++; if (winc !== 1'b1) begin errors++; $display("FAIL single_winc w%0d got %b exp 1", w, winc); end
      checks++; if (wdata !== 8'(w)) begin errors++; $display("FAIL single_wdata w%0d got %h exp %h", w, wdata, 8'(w)); end
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready w%0d got %b exp 0001", w, req_ready); end
      step();
    end
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gap_gnt got %b exp 0000", gnt); end
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL single_gap_winc got %b exp 0", winc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_gap_busy got %b exp 0", busy); end
    checks++; if (wdata !== 8'h00) begin errors++; $display("FAIL single_gap_wdata got %h exp 00", wdata); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_gap_ready got %b exp 0000", req_ready); end
    step();
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_regrant got %b exp 0001", gnt); end
    checks++; if (wdata !== 8'h04) begin errors++; $display("FAIL single_regrant_wdata got %h exp 04", wdata); end
    req_valid = '0;
    step();
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    do_reset();
    req_valid = 4'b1111;
    step();
    for (int b = 0; b < 5; b++) begin
      int g;
      int base;
      g    = b % 4;
      base = (b / 4) * 4;
      eg   = 4'b0001 << g;
      for (int w = 0; w < 4; w++) begin
        #1;
        checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt b%0d w%0d got %b exp %b", b, w, gnt, eg); end
        checks++; if (winc !== 1'b1) begin errors++; $display("FAIL rr_winc b%0d w%0d got %b exp 1", b, w, winc); end
        checks++; if (wdata !== 8'(g * 16 + base + w)) begin
          errors++; $display("FAIL rr_wdata b%0d w%0d got %h exp %h", b, w, wdata, 8'(g * 16 + base + w));
        end
        step();
      end
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_gap b%0d got %b exp 0000", b, gnt); end
      checks++; if (winc !== 1'b0) begin errors++; $display("FAIL rr_gap_winc b%0d got %b exp 0", b, winc); end
      step();
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_full_stall();
    do_reset();
    req_valid = 4'b0100;
    step();
    for (int w = 0; w < 2; w++) begin
      #1;
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL stall_gnt w%0d got %b exp 0100", w, gnt); end
      checks++; if (wdata !== 8'(8'h20 + w)) begin errors++; $display("FAIL stall_wdata w%0d got %h exp %h", w, wdata, 8'(8'h20 + w)); end
      step();
    end
    wfull = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++; if (winc !== 1'b0) begin errors++; $display("FAIL stall_winc s%0d got %b exp 0", s, winc); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready s%0d got %b exp 0000", s, req_ready); end
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL stall_hold s%0d got %b exp 0100", s, gnt); end
      checks++; if (dut.cnt_q !== 3'd2) begin errors++; $display("FAIL stall_cnt s%0d got %0d exp 2", s, dut.cnt_q); end
      step();
    end
    wfull = 1'b0;
    for (int w = 2; w < 4; w++) begin
      #1;
      checks++; if (winc !== 1'b1) begin errors++; $display("FAIL stall_resume_winc w%0d got %b exp 1", w, winc); end
      checks++; if (wdata !== 8'(8'h20 + w)) begin errors++; $display("FAIL stall_resume_wdata w%0d got %h exp %h", w, wdata, 8'(8'h20 + w)); end
      step();
    end
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_end_busy got %b exp 0", busy); end
    checks++; if (wcnt[2] !== 4) begin errors++; $display("FAIL stall_words got %0d exp 4", wcnt[2]); end
    req_valid = '0;
    step();
  endtask

  task automatic test_early_release();
    do_reset();
    req_valid = 4'b1010;
    step();
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL early_gnt got %b exp 0010", gnt); end
    checks++; if (wdata !== 8'h10) begin errors++; $display("FAIL early_wdata got %h exp 10", wdata); end
    step();
    req_valid = 4'b1000;
    #1;
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL early_rel_winc got %b exp 0", winc); end
    checks++; if (dut.cnt_q !== 3'd1) begin errors++; $display("FAIL early_cnt got %0d exp 1", dut.cnt_q); end
    step();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL early_busy got %b exp 0", busy); end
    checks++; if (dut.ptr_q !== 2'd2) begin errors++; $display("FAIL early_ptr got %0d exp 2", dut.ptr_q); end
    step();
    #1;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL early_next_gnt got %b exp 1000", gnt); end
  endtask

  // Continues from the grant to requester 3 left by test_early_release.
  task automatic test_release_full();
    #1;
    checks++; if (wdata !== 8'h30) begin errors++; $display("FAIL relfull_wdata got %h exp 30", wdata); end
    step();
    req_valid = '0;
    wfull     = 1'b1;
    #1;
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL relfull_winc got %b exp 0", winc); end
    step();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL relfull_busy got %b exp 0", busy); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL relfull_gnt got %b exp 0000", gnt); end
    checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL relfull_ptr got %0d exp 0", dut.ptr_q); end
    wfull = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_valid = 4'b0100;
    step();
    for (int w = 0; w < 4; w++) step();
    req_valid = 4'b1001;
    step();
    #1;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rstmid_gnt got %b exp 1000", gnt); end
    step();
    #1;
    checks++; if (winc !== 1'b1) begin errors++; $display("FAIL rstmid_w1_winc got %b exp 1", winc); end
    checks++; if (wdata !== 8'h31) begin errors++; $display("FAIL rstmid_w1_wdata got %h exp 31", wdata); end
    wrst_n = 1'b0;
    #1;
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL rstmid_winc got %b exp 0", winc); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rstmid_gnt0 got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    wrst_n = 1'b1;
    step();
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_regrant got %b exp 0001", gnt); end
    req_valid = '0;
    step();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    wrst_n    = 1'b0;
    req_valid = '0;
    wfull     = 1'b0;
    req_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_release_full();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached before end of test sequence");
    $fatal(1);
  end

endmodule
